// File: rtl/ntt_pkg.sv
// Shared NTT datapath package: default coefficient width/modulus pairing and
// the controller state encoding used by the sequential polynomial units.
package ntt_pkg;

    // Default coefficient width and modulus (smallest legal pairing).
    localparam int DEF_N = 2;
    localparam int DEF_Q = 3;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for walking D coefficients; a single coefficient still
    // needs a one-bit index register.
    function automatic int idx_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/mod_sub.sv
// Single-coefficient modular subtract: d = (a - b) mod Q.
// Purely combinational so it can be shared by an index mux or dropped into a
// butterfly difference leg.
module mod_sub #(
    parameter int N = 2,
    parameter int Q = 3
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] d
);

    localparam logic [N:0] QW = (N+1)'(Q);

    logic [N:0] diff;
    logic [N:0] wrap;

    // One extra bit catches the borrow; on borrow add Q back and drop the MSB.
    // Inputs >= Q still produce this defined value, just not a canonical one.
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        wrap = diff + QW;
        d    = diff[N] ? wrap[N-1:0] : diff[N-1:0];
    end

endmodule

// File: rtl/poly_sub_mod.sv
// Sequential modular polynomial subtractor: s[i] = (a[i] - b[i]) mod Q,
// one coefficient per clock behind a start/busy/done handshake.
// Coefficient i lives at bits [(i+1)*N-1 : i*N] of a, b and s.
module poly_sub_mod
    import ntt_pkg::*;
#(
    parameter int D = 2,
    parameter int N = DEF_N,
    parameter int Q = DEF_Q
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [D*N-1:0] a,
    input  logic [D*N-1:0] b,
    output logic [D*N-1:0] s,
    output logic           busy,
    output logic           done
);

    localparam int IW = idx_width(D);
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    typedef logic [D-1:0][N-1:0] poly_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    poly_t         a_r;
    poly_t         b_r;
    poly_t         s_r;

    logic          accept;
    logic          wr_en;
    logic          last;

    logic [N-1:0]  a_sel;
    logic [N-1:0]  b_sel;
    logic [N-1:0]  d_sel;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: DONE accepts a new job exactly like IDLE, so back-to-back
    // jobs lose no cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control strobes derived from the current state; start during RUN is ignored.
    always_comb begin
        accept = start && ((state == IDLE) || (state == DONE));
        wr_en  = (state == RUN);
        last   = wr_en && (idx == LAST_IDX);
    end

    // One shared subtractor walks the coefficients through an idx mux.
    assign a_sel = a_r[idx];
    assign b_sel = b_r[idx];

    mod_sub #(.N(N), .Q(Q)) u_sub (
        .a (a_sel),
        .b (b_sel),
        .d (d_sel)
    );

    // Datapath: operand capture on accept, one coefficient written per RUN
    // cycle, busy/done bookkeeping. done is a one-cycle registered pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            s_r  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_r  <= a;
                b_r  <= b;
                idx  <= '0;
                busy <= 1'b1;
            end
            if (wr_en) begin
                s_r[idx] <= d_sel;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    assign s = s_r;

endmodule

// File: tb/tb_poly_sub_mod.sv
// Scoreboard bench for poly_sub_mod: three instances (D2/N2/Q3, D4/N4/Q13,
// D1/N4/Q13). Stimulus pushes expected results; a negedge monitor pops and
// compares whenever an instance pulses done.
module tb_poly_sub_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rn0, rn1, rn2;
    logic        st0, st1, st2;
    logic [3:0]  a0, b0, s0;
    logic [15:0] a1, b1, s1;
    logic [3:0]  a2, b2, s2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;

    poly_sub_mod #(.D(2), .N(2), .Q(3)) u0 (
        .clk(clk), .rst_n(rn0), .start(st0), .a(a0), .b(b0),
        .s(s0), .busy(busy0), .done(done0));

    poly_sub_mod #(.D(4), .N(4), .Q(13)) u1 (
        .clk(clk), .rst_n(rn1), .start(st1), .a(a1), .b(b1),
        .s(s1), .busy(busy1), .done(done1));

    poly_sub_mod #(.D(1), .N(4), .Q(13)) u2 (
        .clk(clk), .rst_n(rn2), .start(st2), .a(a2), .b(b2),
        .s(s2), .busy(busy2), .done(done2));

    logic [15:0] s_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    assign s_v[0] = {12'd0, s0};
    assign s_v[1] = s1;
    assign s_v[2] = {12'd0, s2};
    assign busy_v[0] = busy0;
    assign busy_v[1] = busy1;
    assign busy_v[2] = busy2;
    assign done_v[0] = done0;
    assign done_v[1] = done1;
    assign done_v[2] = done2;

    typedef struct {
        int          u;
        logic [15:0] v;
    } sb_t;
    sb_t sbq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic st, input logic [15:0] av, input logic [15:0] bv);
        case (u)
            0: begin st0 = st; a0 = av[3:0]; b0 = bv[3:0]; end
            1: begin st1 = st; a1 = av;      b1 = bv;      end
            default: begin st2 = st; a2 = av[3:0]; b2 = bv[3:0]; end
        endcase
    endtask

    // Called just after the accept edge: counts busy cycles and edges until
    // done rises; both must equal D.
    task automatic wait_done(input int u, input int d);
        int cyc = 0;
        int bc  = 0;
        bit seen = 0;
        repeat (20) begin
            if (busy_v[u] === 1'b1) bc++;
            tick();
            cyc++;
            if (done_v[u] === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", 16'(seen), 16'd1);
        chk("done_latency", 16'(cyc), 16'(d));
        chk("busy_cycles", 16'(bc), 16'(d));
    endtask

    task automatic run_job(input int u, input int d, input logic [15:0] av,
                           input logic [15:0] bv, input logic [15:0] ex);
        drive(u, 1'b1, av, bv);
        sbq.push_back('{u, ex});
        tick();
        drive(u, 1'b0, av, bv);
        wait_done(u, d);
        tick();
        chk("done_pulse_width", 16'(done_v[u]), 16'd0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (done_v[u] === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 16'(u), 16'hFFFF);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_instance", 16'(u), 16'(e.u));
                    chk("sb_result", s_v[u], e.v);
                end
            end
        end
    end

    initial begin
        rn0 = 0; rn1 = 0; rn2 = 0;
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 16'd0, 16'd0);
        drive(2, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            chk("reset_s", s_v[u], 16'd0);
            chk("reset_busy", 16'(busy_v[u]), 16'd0);
            chk("reset_done", 16'(done_v[u]), 16'd0);
        end
        rn0 = 1; rn1 = 1; rn2 = 1;
        tick();

        // D=2,N=2,Q=3: a={0,2}, b={2,1} -> s={1,1}
        run_job(0, 2, 16'h0002, 16'h0009, 16'h0005);

        // D=4,N=4,Q=13: [5,0,12,7]-[3,1,12,9] -> [2,12,0,11]
        run_job(1, 4, 16'h7C05, 16'h9C13, 16'hB0C2);

        // Held start: second operands appear during busy, accepted in DONE.
        drive(1, 1'b1, 16'h7C05, 16'h9C13);
        sbq.push_back('{1, 16'hB0C2});
        sbq.push_back('{1, 16'hCCCC});
        tick();
        drive(1, 1'b1, 16'h1111, 16'h2222);
        wait_done(1, 4);
        tick();
        drive(1, 1'b0, 16'h1111, 16'h2222);
        chk("b2b_done_low", 16'(done1), 16'd0);
        chk("b2b_busy_high", 16'(busy1), 16'd1);
        wait_done(1, 4);
        tick();
        chk("b2b_done_pulse_width", 16'(done1), 16'd0);

        // Reset two cycles into a job: aborted, no done, s cleared.
        drive(1, 1'b1, 16'h7C05, 16'h9C13);
        tick();
        drive(1, 1'b0, 16'h7C05, 16'h9C13);
        tick();
        tick();
        rn1 = 0;
        tick();
        rn1 = 1;
        chk("abort_s", s1, 16'd0);
        chk("abort_busy", 16'(busy1), 16'd0);
        chk("abort_done", 16'(done1), 16'd0);
        repeat (6) begin
            tick();
            chk("abort_no_done", 16'(done1), 16'd0);
        end
        // [0,1,2,3]-[3,2,1,0] -> [10,12,1,3]
        run_job(1, 4, 16'h3210, 16'h0123, 16'h31CA);

        // D=1: 0 - 12 mod 13 = 1
        run_job(2, 1, 16'd0, 16'd12, 16'd1);

        // Full residue sweep on the single-coefficient instance.
        for (int x = 0; x < 13; x++) begin
            for (int y = 0; y < 13; y++) begin
                run_job(2, 1, 16'(x), 16'(y), 16'((x - y + 13) % 13));
            end
        end

        tick();
        chk("sb_drained", 16'(sbq.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
